// File: rtl/config_chain_loader.sv
// rtl/config_chain_loader.sv - serial configuration chain loader with shadow commit (optional CONFIG_CHAIN_PARITY_EN)
module config_chain_loader #(
  parameter int WIDTH  = 1,
  parameter int LENGTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      shift_enable,
  input  logic [WIDTH-1:0]          shift_in,
  output logic [WIDTH-1:0]          shift_out,
  output logic                      busy,
  output logic                      config_valid,
  output logic [WIDTH*LENGTH-1:0]   config_data,
  output logic                      error
);

  localparam int N  = WIDTH * LENGTH;
  localparam int CW = $clog2(LENGTH + 1);

`ifdef CONFIG_CHAIN_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CHECK = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1} state_t;
`endif

  state_t          state, state_n;
  logic [N-1:0]    chain, chain_n;
  logic [N-1:0]    shadow, shadow_n;
  logic [CW-1:0]   count, count_n;
  logic            valid, valid_n;
  logic            err, err_n;
  logic [N-1:0]    shifted;
  logic            last_beat;

  // Chain value after accepting the current beat; the oldest beat falls off the top.
  assign shifted   = (chain << WIDTH) | N'(shift_in);
  assign last_beat = (count == CW'(LENGTH - 1));

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      chain  <= '0;
      shadow <= '0;
      count  <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      chain  <= chain_n;
      shadow <= shadow_n;
      count  <= count_n;
      valid  <= valid_n;
      err    <= err_n;
    end
  end

  // Next-state logic: start always restarts the frame and takes priority over any beat.
  always_comb begin
    state_n  = state;
    chain_n  = chain;
    shadow_n = shadow;
    count_n  = count;
    valid_n  = valid;
    err_n    = err;
    if (start) begin
      state_n = LOAD;
      count_n = '0;
      valid_n = 1'b0;
      err_n   = 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (shift_enable) begin
            chain_n = shifted;
            count_n = count + CW'(1);
            if (last_beat) begin
`ifdef CONFIG_CHAIN_PARITY_EN
              state_n = CHECK;
`else
              shadow_n = shifted;
              valid_n  = 1'b1;
              state_n  = IDLE;
`endif
            end
          end
        end
`ifdef CONFIG_CHAIN_PARITY_EN
        CHECK: begin
          if (shift_enable) begin
            if (shift_in[0] == ^chain) begin
              shadow_n = chain;
              valid_n  = 1'b1;
            end else begin
              err_n = 1'b1;
            end
            state_n = IDLE;
          end
        end
`endif
        default: state_n = IDLE;
      endcase
    end
  end

  assign shift_out    = chain[N-1 -: WIDTH];
  assign busy         = (state != IDLE);
  assign config_valid = valid;
  assign config_data  = shadow;
  assign error        = err;

endmodule

// File: tb/tb_config_chain_loader.sv
// tb/tb_config_chain_loader.sv - self-checking bench for config_chain_loader
module tb_config_chain_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        shift_enable = 1'b0;
  logic [3:0]  shift_in = '0;
  logic [3:0]  shift_out;
  logic        busy, config_valid, error;
  logic [15:0] config_data;
  logic [3:0]  u1_so, u1_data;
  logic        u1_busy, u1_valid, u1_err;

  int checks = 0;
  int errors = 0;

  config_chain_loader #(.WIDTH(4), .LENGTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .shift_enable(shift_enable),
    .shift_in(shift_in), .shift_out(shift_out), .busy(busy),
    .config_valid(config_valid), .config_data(config_data), .error(error)
  );

  config_chain_loader #(.WIDTH(4), .LENGTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .shift_enable(shift_enable),
    .shift_in(shift_in), .shift_out(u1_so), .busy(u1_busy),
    .config_valid(u1_valid), .config_data(u1_data), .error(u1_err)
  );

  always #5 clk = ~clk;

  // Behavioural reference: beats counted per frame, chain kept as a 16-bit number.
  int          m_beats;
  bit          m_loading, m_checking, m_valid, m_err;
  logic [15:0] m_chain, m_data;

  task automatic model_reset();
    m_beats = 0; m_loading = 0; m_checking = 0; m_valid = 0; m_err = 0;
    m_chain = '0; m_data = '0;
  endtask

  task automatic model_step(input logic st, input logic se, input logic [3:0] si);
    if (st) begin
      m_loading = 1; m_checking = 0; m_beats = 0; m_valid = 0; m_err = 0;
    end else if (m_checking && se) begin
      m_checking = 0;
      if (si[0] == ($countones(m_chain) % 2)) begin
        m_data = m_chain; m_valid = 1;
      end else begin
        m_err = 1;
      end
    end else if (m_loading && se) begin
      m_chain = 16'((m_chain * 16) + si);
      m_beats = m_beats + 1;
      if (m_beats == 4) begin
        m_loading = 0;
`ifdef CONFIG_CHAIN_PARITY_EN
        m_checking = 1;
`else
        m_data = m_chain; m_valid = 1;
`endif
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valid"}, 32'(config_valid), 32'(m_valid));
    check({tag, ".data"},  32'(config_data),  32'(m_data));
    check({tag, ".busy"},  32'(busy),         32'(m_loading || m_checking));
    check({tag, ".so"},    32'(shift_out),    32'(m_chain >> 12));
    check({tag, ".err"},   32'(error),        32'(m_err));
  endtask

  task automatic cyc(input logic st, input logic se, input logic [3:0] si);
    start = st; shift_enable = se; shift_in = si;
    @(posedge clk); #1;
    model_step(st, se, si);
  endtask

  typedef struct {
    logic st; logic se; logic [3:0] si;
    logic ev; logic [15:0] ed; logic eb; logic [3:0] eso;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic se, input logic [3:0] si,
                              input logic ev, input logic [15:0] ed, input logic eb,
                              input logic [3:0] eso);
    vec_t v;
    v.st = st; v.se = se; v.si = si; v.ev = ev; v.ed = ed; v.eb = eb; v.eso = eso;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    model_reset();
    #12;
    check("reset.valid", 32'(config_valid), 0);
    check("reset.data",  32'(config_data), 0);
    check("reset.busy",  32'(busy), 0);
    check("reset.so",    32'(shift_out), 0);
    check("reset.err",   32'(error), 0);
    @(negedge clk); rst = 1'b1;

`ifndef CONFIG_CHAIN_PARITY_EN
    // Basic load, stalled load, idle beat ignored, start beats shift_enable in idle.
    tbl.push_back(mk(1, 0, 4'h0, 0, 16'h0000, 1, 4'h0));
    tbl.push_back(mk(0, 1, 4'h1, 0, 16'h0000, 1, 4'h0));
    tbl.push_back(mk(0, 1, 4'h2, 0, 16'h0000, 1, 4'h0));
    tbl.push_back(mk(0, 1, 4'h3, 0, 16'h0000, 1, 4'h0));
    tbl.push_back(mk(0, 1, 4'h4, 1, 16'h1234, 0, 4'h1));
    tbl.push_back(mk(1, 0, 4'h0, 0, 16'h1234, 1, 4'h1));
    tbl.push_back(mk(0, 1, 4'h1, 0, 16'h1234, 1, 4'h2));
    tbl.push_back(mk(0, 1, 4'h2, 0, 16'h1234, 1, 4'h3));
    tbl.push_back(mk(0, 0, 4'hF, 0, 16'h1234, 1, 4'h3));
    tbl.push_back(mk(0, 0, 4'hF, 0, 16'h1234, 1, 4'h3));
    tbl.push_back(mk(0, 0, 4'hF, 0, 16'h1234, 1, 4'h3));
    tbl.push_back(mk(0, 1, 4'h3, 0, 16'h1234, 1, 4'h4));
    tbl.push_back(mk(0, 1, 4'h4, 1, 16'h1234, 0, 4'h1));
    tbl.push_back(mk(0, 1, 4'h9, 1, 16'h1234, 0, 4'h1));
    tbl.push_back(mk(1, 1, 4'h7, 0, 16'h1234, 1, 4'h1));
    tbl.push_back(mk(0, 0, 4'h0, 0, 16'h1234, 1, 4'h1));
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].st, tbl[i].se, tbl[i].si);
      check($sformatf("tbl%0d.valid", i), 32'(config_valid), 32'(tbl[i].ev));
      check($sformatf("tbl%0d.data", i),  32'(config_data),  32'(tbl[i].ed));
      check($sformatf("tbl%0d.busy", i),  32'(busy),         32'(tbl[i].eb));
      check($sformatf("tbl%0d.so", i),    32'(shift_out),    32'(tbl[i].eso));
      check($sformatf("tbl%0d.err", i),   32'(error),        0);
    end

    // Restart mid-frame keeps the old commit until the new one lands.
    cyc(1, 0, 0); cyc(0, 1, 4'hA); cyc(0, 1, 4'hB);
    check("restart.valid", 32'(config_valid), 0);
    check("restart.data", 32'(config_data), 32'h1234);
    cyc(1, 1, 4'hE); cyc(0, 1, 4'h5); cyc(0, 1, 4'h6); cyc(0, 1, 4'h7);
    check("restart2.data", 32'(config_data), 32'h1234);
    check("restart2.valid", 32'(config_valid), 0);
    cyc(0, 1, 4'h8);
    check("restart3.data", 32'(config_data), 32'h5678);
    check("restart3.valid", 32'(config_valid), 1);

    // Single-beat frame on the LENGTH=1 instance.
    cyc(1, 0, 0); cyc(0, 1, 4'h9);
    check("len1.valid", 32'(u1_valid), 1);
    check("len1.data", 32'(u1_data), 32'h9);
    check("len1.busy", 32'(u1_busy), 0);
    check("len1.so", 32'(u1_so), 32'h9);
    check("len1.err", 32'(u1_err), 0);
    compare_model("len1main");
`else
    // Parity build: good parity commits, bad parity flags error and keeps data.
    cyc(1, 0, 0); cyc(0, 1, 4'h3); cyc(0, 1, 4'h1); cyc(0, 1, 4'h0); cyc(0, 1, 4'h0);
    check("par.busy", 32'(busy), 1);
    check("par.valid0", 32'(config_valid), 0);
    cyc(0, 1, 4'h1);
    check("par.data", 32'(config_data), 32'h3100);
    check("par.valid", 32'(config_valid), 1);
    check("par.err", 32'(error), 0);
    cyc(1, 0, 0); cyc(0, 1, 4'h3); cyc(0, 1, 4'h1); cyc(0, 1, 4'h0); cyc(0, 1, 4'h0);
    cyc(0, 1, 4'h0);
    check("parbad.err", 32'(error), 1);
    check("parbad.valid", 32'(config_valid), 0);
    check("parbad.data", 32'(config_data), 32'h3100);
    check("parbad.busy", 32'(busy), 0);
`endif

    // Asynchronous reset mid-frame, then beats without start are ignored.
    cyc(1, 0, 0); cyc(0, 1, 4'h1); cyc(0, 1, 4'h2);
    #2 rst = 1'b0; #1;
    model_reset();
    check("arst.valid", 32'(config_valid), 0);
    check("arst.data", 32'(config_data), 0);
    check("arst.busy", 32'(busy), 0);
    check("arst.so", 32'(shift_out), 0);
    check("arst.err", 32'(error), 0);
    @(negedge clk); rst = 1'b1;
    cyc(0, 1, 4'h7); cyc(0, 1, 4'h7);
    compare_model("noload");
    check("noload.busy", 32'(busy), 0);
    cyc(1, 0, 0); cyc(0, 1, 4'h1); cyc(0, 1, 4'h2); cyc(0, 1, 4'h3); cyc(0, 1, 4'h4);
`ifdef CONFIG_CHAIN_PARITY_EN
    cyc(0, 1, 4'h1);
`endif
    compare_model("reload");
    check("reload.data", 32'(config_data), 32'h1234);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0), 4'($urandom));
      compare_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
